// File: rtl/mac_pkg.sv
// Shared constants, width helpers and the beat tag carried alongside every
// beat through the mac_stream_unit pipeline.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_LANES  = 4;

    // Control flags that travel with a beat from acceptance to Stage A.
    typedef struct packed {
        logic first;
        logic last;
        logic signed_mode;
    } beat_tag_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // One guard bit above the worst-case signed or unsigned lane sum.
    function automatic int sum_width(input int data_w, input int lanes);
        return 2 * data_w + clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One lane of Stage P: extends both operands per the beat's mode and
// registers their 2*DATA_W-bit product.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  signed_mode,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] w_a_wide;
    logic [PROD_W-1:0] w_b_wide;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] r_prod;

    // Operands widened to the product width so the low PROD_W bits of the
    // multiply are exact for both signed and unsigned operands.
    assign w_a_wide = signed_mode ? PROD_W'($signed(a)) : PROD_W'(a);
    assign w_b_wide = signed_mode ? PROD_W'($signed(b)) : PROD_W'(b);
    assign w_prod   = w_a_wide * w_b_wide;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod <= '0;
        end else if (en) begin
            r_prod <= w_prod;
        end
    end

    assign prod = r_prod;

endmodule

// File: rtl/mac_stream_unit.sv
// Multi-lane pipelined multiply-accumulate over framed beats (P -> S -> A)
// with a valid/ready result register. Define MAC_SATURATE_EN for saturation.
module mac_stream_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic                      signed_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_acc,
    output logic                      out_ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = sum_width(DATA_W, LANES);

    logic              w_stall;
    logic              w_en;
    beat_tag_t         w_in_tag;

    logic              r_p_valid;
    beat_tag_t         r_p_tag;
    logic [PROD_W-1:0] w_prod     [LANES];
    logic [SUM_W-1:0]  w_prod_ext [LANES];
    logic [SUM_W-1:0]  w_lane_sum;

    logic              r_s_valid;
    beat_tag_t         r_s_tag;
    logic [SUM_W-1:0]  r_sum;

    logic [ACC_W-1:0]  w_sum_ext;
    logic [ACC_W-1:0]  w_acc_base;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_acc_load;
    logic              w_out_load;
    logic [ACC_W-1:0]  r_acc;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_acc;

    // A held result that nobody takes freezes every stage at once.
    assign w_stall  = r_out_valid && !out_ready;
    assign w_en     = !w_stall;
    assign in_ready = !w_stall;

    assign w_in_tag.first       = in_first;
    assign w_in_tag.last        = in_last;
    assign w_in_tag.signed_mode = signed_mode;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mac_lane #(
                .DATA_W (DATA_W)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .en          (w_en),
                .signed_mode (signed_mode),
                .a           (in_a[gi*DATA_W +: DATA_W]),
                .b           (in_b[gi*DATA_W +: DATA_W]),
                .prod        (w_prod[gi])
            );

            assign w_prod_ext[gi] = r_p_tag.signed_mode ? SUM_W'($signed(w_prod[gi]))
                                                        : SUM_W'(w_prod[gi]);
        end
    endgenerate

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + w_prod_ext[i];
        end
    end

    // Stage valids and tags shadow the lane product registers (Stage P) and
    // the lane sum register (Stage S).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_valid <= 1'b0;
            r_p_tag   <= '0;
            r_s_valid <= 1'b0;
            r_s_tag   <= '0;
            r_sum     <= '0;
        end else if (w_en) begin
            r_p_valid <= in_valid;
            r_p_tag   <= w_in_tag;
            r_s_valid <= r_p_valid;
            r_s_tag   <= r_p_tag;
            r_sum     <= w_lane_sum;
        end
    end

    assign w_sum_ext  = r_s_tag.signed_mode ? ACC_W'($signed(r_sum)) : ACC_W'(r_sum);
    assign w_acc_base = r_s_tag.first ? '0 : r_acc;
    assign w_acc_load = w_en && r_s_valid;
    assign w_out_load = w_acc_load && r_s_tag.last;

`ifdef MAC_SATURATE_EN
    logic [ACC_W:0] w_wide_s;
    logic [ACC_W:0] w_wide_u;
    logic           w_ovf_beat;
    logic           w_flag_next;
    logic           r_ovf_flag;
    logic           r_out_ovf;

    assign w_wide_s = {w_acc_base[ACC_W-1], w_acc_base} + {w_sum_ext[ACC_W-1], w_sum_ext};
    assign w_wide_u = {1'b0, w_acc_base} + {1'b0, w_sum_ext};

    // Signed overflow shows as disagreement between the guard bit and the MSB;
    // unsigned overflow as a carry out of the accumulator width.
    always_comb begin
        w_acc_next = w_wide_u[ACC_W-1:0];
        w_ovf_beat = 1'b0;
        if (r_s_tag.signed_mode) begin
            w_acc_next = w_wide_s[ACC_W-1:0];
            if (w_wide_s[ACC_W] != w_wide_s[ACC_W-1]) begin
                w_ovf_beat = 1'b1;
                w_acc_next = w_wide_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (w_wide_u[ACC_W]) begin
            w_ovf_beat = 1'b1;
            w_acc_next = '1;
        end
    end

    assign w_flag_next = r_s_tag.first ? w_ovf_beat : (r_ovf_flag | w_ovf_beat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_flag <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (w_acc_load) begin
                r_ovf_flag <= w_flag_next;
            end
            if (w_out_load) begin
                r_out_ovf <= w_flag_next;
            end
        end
    end

    assign out_ovf = r_out_ovf;
`else
    assign w_acc_next = w_acc_base + w_sum_ext;
    assign out_ovf    = 1'b0;
`endif

    // A new last result takes priority over the consume of the previous one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
        end else begin
            if (w_acc_load) begin
                r_acc <= w_acc_next;
            end
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_acc   <= w_acc_next;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;

endmodule

// File: tb/tb_mac_stream_unit.sv
// Scoreboard bench for mac_stream_unit: a default 4-lane instance plus a
// narrow 1-lane/18-bit instance for the overflow case.
module tb_mac_stream_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_first, in_last, signed_mode, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_acc;

    logic        n_valid, n_first, n_last, n_sm, n_out_ready;
    logic [7:0]  n_a, n_b;
    logic        n_in_ready, n_out_valid, n_ovf;
    logic [17:0] n_acc;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    mac_stream_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_first    (in_first),
        .in_last     (in_last),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_ovf     (out_ovf)
    );

    mac_stream_unit #(.DATA_W(8), .ACC_W(18), .LANES(1)) dut_n (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (n_valid),
        .in_ready    (n_in_ready),
        .in_a        (n_a),
        .in_b        (n_b),
        .in_first    (n_first),
        .in_last     (n_last),
        .signed_mode (n_sm),
        .out_valid   (n_out_valid),
        .out_ready   (n_out_ready),
        .out_acc     (n_acc),
        .out_ovf     (n_ovf)
    );

    // Reference dot product of one beat, 4 lanes of 8 bits.
    function automatic logic [31:0] beat_dot(input logic [31:0] a, input logic [31:0] b,
                                             input logic sm);
        longint s;
        longint x;
        longint y;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (sm) begin
                x = longint'($signed(a[i*8 +: 8]));
                y = longint'($signed(b[i*8 +: 8]));
            end else begin
                x = longint'({1'b0, a[i*8 +: 8]});
                y = longint'({1'b0, b[i*8 +: 8]});
            end
            s = s + x * y;
        end
        return s[31:0];
    endfunction

    // Offers one beat from a falling edge and returns on the falling edge
    // after the rising edge that accepted it.
    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                              input logic f, input logic l, input logic sm);
        logic ok;
        in_a = a; in_b = b; in_first = f; in_last = l; signed_mode = sm;
        in_valid = 1'b1;
        ok = 1'b0;
        while (!ok) begin
            #4;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total += 6;
        if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_acc !== 32'd0)   begin bad++; $display("FAIL reset_out_acc: got %0d want 0", out_acc); end
        if (out_ovf !== 1'b0)    begin bad++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        if (n_out_valid !== 1'b0) begin bad++; $display("FAIL reset_n_valid: got %b want 0", n_out_valid); end
        if (n_acc !== 18'd0)     begin bad++; $display("FAIL reset_n_acc: got %0d want 0", n_acc); end
        $display("reset: in_ready=%b out_valid=%b out_acc=%0d", in_ready, out_valid, out_acc);
    endtask

    task automatic test_single_latency();
        @(negedge clk);
        out_ready = 1'b1;
        drive_beat(32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            total++;
            if (out_valid !== (k == 3)) begin
                bad++; $display("FAIL latency_valid_e%0d: got %b want %b", k, out_valid, (k == 3));
            end
        end
        total++;
        if (out_acc !== 32'd70) begin bad++; $display("FAIL single_acc: got %0d want 70", out_acc); end
        $display("single beat: out_acc=%0d", out_acc);
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_consumed: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int got = 0, cyc = 0, c0 = -1, c1 = -1;
        logic [31:0] exp;
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'd196608);
        exp_q.push_back(32'd4);
        fork
            begin
                drive_beat(32'h80808080, 32'h80808080, 1'b1, 1'b0, 1'b1);
                drive_beat(32'h80808080, 32'h80808080, 1'b0, 1'b0, 1'b1);
                drive_beat(32'h80808080, 32'h80808080, 1'b0, 1'b1, 1'b1);
                drive_beat(32'h01010101, 32'h01010101, 1'b1, 1'b1, 1'b1);
            end
            begin
                while (got < 2 && cyc < 40) begin
                    @(negedge clk); #1; cyc++;
                    if (out_valid && out_ready) begin
                        exp = exp_q.pop_front();
                        total++;
                        if (out_acc !== exp) begin bad++; $display("FAIL b2b_acc: got %0d want %0d", out_acc, exp); end
                        $display("back_to_back result %0d: out_acc=%0d", got, out_acc);
                        if (got == 0) c0 = cyc; else c1 = cyc;
                        got++;
                    end
                end
                total += 2;
                if (got != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", got); end
                if (c1 - c0 != 1) begin bad++; $display("FAIL b2b_gap: got %0d want 1", c1 - c0); end
            end
        join
    endtask

    task automatic test_ff_modes();
        int got = 0, cyc = 0;
        logic [31:0] exp;
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'd260100);
        exp_q.push_back(32'd4);
        fork
            begin
                drive_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
                drive_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
            end
            begin
                while (got < 2 && cyc < 40) begin
                    @(negedge clk); #1; cyc++;
                    if (out_valid && out_ready) begin
                        exp = exp_q.pop_front();
                        total += 2;
                        if (out_acc !== exp) begin bad++; $display("FAIL ff_acc: got %0d want %0d", out_acc, exp); end
                        if (out_ovf !== 1'b0) begin bad++; $display("FAIL ff_ovf: got %b want 0", out_ovf); end
                        $display("ff mode result %0d: out_acc=%0d", got, out_acc);
                        got++;
                    end
                end
                total++;
                if (got != 2) begin bad++; $display("FAIL ff_count: got %0d want 2", got); end
            end
        join
    endtask

    task automatic test_stall();
        int got = 0, cyc = 0;
        logic [31:0] exp;
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1024);
        out_ready = 1'b0;
        fork
            begin
                drive_beat(32'h01010101, 32'h02020202, 1'b1, 1'b1, 1'b1);
                drive_beat(32'h01020304, 32'h01010101, 1'b1, 1'b0, 1'b1);
                drive_beat(32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b1, 1'b1);
                drive_beat(32'h80808080, 32'h02020202, 1'b1, 1'b1, 1'b0);
            end
            begin
                while (!out_valid && cyc < 50) begin
                    @(negedge clk); #1; cyc++;
                end
                total++;
                if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_wait: got %b want 1", out_valid); end
                exp = exp_q.pop_front();
                repeat (5) begin
                    @(negedge clk); #1;
                    total += 3;
                    if (in_ready !== 1'b0)  begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                    if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", out_valid); end
                    if (out_acc !== exp)    begin bad++; $display("FAIL stall_acc: got %0d want %0d", out_acc, exp); end
                end
                $display("stall held: out_acc=%0d in_ready=%b", out_acc, in_ready);
                out_ready = 1'b1;
                cyc = 0;
                while (got < 2 && cyc < 40) begin
                    @(negedge clk); #1; cyc++;
                    if (out_valid && out_ready) begin
                        exp = exp_q.pop_front();
                        total++;
                        if (out_acc !== exp) begin bad++; $display("FAIL stall_resume_acc: got %0d want %0d", out_acc, exp); end
                        $display("stall resume result %0d: out_acc=%0d", got, out_acc);
                        got++;
                    end
                end
                total++;
                if (got != 2) begin bad++; $display("FAIL stall_count: got %0d want 2", got); end
            end
        join
    endtask

    task automatic test_random();
        logic [31:0] qa[$], qb[$];
        logic        qf[$], ql[$], qs[$];
        logic [31:0] acc, a, b, exp;
        logic        sm;
        int          nb, got = 0, cyc = 0, nframes = 6;
        @(negedge clk);
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            sm = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            acc = 32'd0;
            for (int k = 0; k < nb; k++) begin
                a = $urandom; b = $urandom;
                qa.push_back(a); qb.push_back(b);
                qf.push_back(k == 0); ql.push_back(k == nb - 1); qs.push_back(sm);
                acc = acc + beat_dot(a, b, sm);
            end
            exp_q.push_back(acc);
        end
        fork
            begin
                while (qa.size() > 0) begin
                    drive_beat(qa.pop_front(), qb.pop_front(), qf.pop_front(),
                               ql.pop_front(), qs.pop_front());
                end
            end
            begin
                while (got < nframes && cyc < 400) begin
                    @(negedge clk); #1; cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        exp = exp_q.pop_front();
                        total++;
                        if (out_acc !== exp) begin bad++; $display("FAIL rand_acc: got %0d want %0d", out_acc, exp); end
                        $display("random frame %0d: out_acc=%0d", got, out_acc);
                        got++;
                    end
                end
                total++;
                if (got != nframes) begin bad++; $display("FAIL rand_count: got %0d want %0d", got, nframes); end
                out_ready = 1'b1;
            end
        join
    endtask

    task automatic test_reset_midframe();
        int got = 0, cyc = 0;
        logic [31:0] exp;
        @(negedge clk);
        out_ready = 1'b0;
        drive_beat(32'h01010101, 32'h01010101, 1'b1, 1'b1, 1'b1);
        drive_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b0, 1'b1);
        drive_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0, 1'b0, 1'b1);
        #1;
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        if (out_acc !== 32'd4)  begin bad++; $display("FAIL pre_reset_acc: got %0d want 4", out_acc); end
        reset = 1'b1;
        #1;
        total += 4;
        if (out_valid !== 1'b0)   begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        if (out_acc !== 32'd0)    begin bad++; $display("FAIL midreset_out_acc: got %0d want 0", out_acc); end
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        if (dut.r_acc !== 32'd0)  begin bad++; $display("FAIL midreset_acc: got %0d want 0", dut.r_acc); end
        $display("mid-frame reset: out_valid=%b acc=%0d", out_valid, dut.r_acc);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'd24);
        exp_q.push_back(32'd20);
        fork
            begin
                drive_beat(32'h03030303, 32'h02020202, 1'b0, 1'b1, 1'b1);
                drive_beat(32'h05050505, 32'h01010101, 1'b1, 1'b1, 1'b1);
            end
            begin
                while (got < 2 && cyc < 40) begin
                    @(negedge clk); #1; cyc++;
                    if (out_valid && out_ready) begin
                        exp = exp_q.pop_front();
                        total++;
                        if (out_acc !== exp) begin bad++; $display("FAIL post_reset_acc: got %0d want %0d", out_acc, exp); end
                        $display("post reset result %0d: out_acc=%0d", got, out_acc);
                        got++;
                    end
                end
                total++;
                if (got != 2) begin bad++; $display("FAIL post_reset_count: got %0d want 2", got); end
            end
        join
    endtask

    task automatic test_narrow_overflow();
        int cyc;
        logic [17:0] exp_acc;
        logic        exp_ovf;
`ifdef MAC_SATURATE_EN
        exp_acc = 18'd131071;
        exp_ovf = 1'b1;
`else
        exp_acc = 18'h20000;
        exp_ovf = 1'b0;
`endif
        for (int frame = 0; frame < 2; frame++) begin
            @(negedge clk);
            for (int k = 0; k < ((frame == 0) ? 8 : 1); k++) begin
                n_a = 8'h80; n_b = 8'h80; n_sm = 1'b1;
                n_first = (k == 0); n_last = (frame == 0) ? (k == 7) : 1'b1;
                n_valid = 1'b1;
                @(negedge clk);
            end
            n_valid = 1'b0;
            cyc = 0;
            #1;
            while (!n_out_valid && cyc < 10) begin
                @(negedge clk); #1; cyc++;
            end
            total += 3;
            if (n_out_valid !== 1'b1) begin bad++; $display("FAIL narrow_valid%0d: got %b want 1", frame, n_out_valid); end
            if (frame == 0) begin
                if (n_acc !== exp_acc) begin bad++; $display("FAIL narrow_acc: got %0d want %0d", n_acc, exp_acc); end
                if (n_ovf !== exp_ovf) begin bad++; $display("FAIL narrow_ovf: got %b want %b", n_ovf, exp_ovf); end
            end else begin
                if (n_acc !== 18'd16384) begin bad++; $display("FAIL narrow_clear_acc: got %0d want 16384", n_acc); end
                if (n_ovf !== 1'b0)      begin bad++; $display("FAIL narrow_clear_ovf: got %b want 0", n_ovf); end
            end
            $display("narrow frame %0d: acc=%0d ovf=%b", frame, n_acc, n_ovf);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        n_valid = 1'b0; n_first = 1'b0; n_last = 1'b0; n_sm = 1'b0;
        n_a = '0; n_b = '0; n_out_ready = 1'b1;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_single_latency();
        test_back_to_back();
        test_ff_modes();
        test_stall();
        test_random();
        test_reset_midframe();
        test_narrow_overflow();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
